// File: rtl/conv_paralelo.sv
//-----------------------------------------------------------------------------
// conv_paralelo
//
// Receive-side byte-to-parallel converter. Reassembles an incoming byte
// stream into 32-, 16- or 8-bit words, selected by the PIPE-style PCLK code.
// The transmitter sends the most-significant byte first, so the first byte of
// a word ends up in the MS byte of the selected width. The result is
// right-aligned on a 32-bit bus, and any unused upper bits are zero.
//
// Ports:
//   CLK        byte clock; all logic runs on the rising edge
//   RST        asynchronous active-high reset
//   ENB        block enable; when low, input is ignored and a partial word is
//              dropped silently
//   PCLK[1:0]  width select: 00 = 4 bytes, 01 = 2 bytes, 10 = 1 byte,
//              11 = reserved
//   in_valid   'in' carries a valid byte this cycle
//   in[7:0]    incoming byte
//   out[31:0]  last completed word; holds until the next completion
//   valid_out  one-cycle pulse: 'out' was just updated with a complete word
//   err        one-cycle pulse: partial word aborted by a width change, or a
//              byte arrived with the reserved PCLK code
//   err_cnt    (only with CONV_ERR_CNT_EN) saturating count of err pulses
//
// Handshake: a byte is accepted on a rising edge where ENB=1 and in_valid=1.
// There is no backpressure. valid_out is a single-cycle strobe that follows
// the edge on which the last byte of a word is sampled.
//
// Optional feature macro: CONV_ERR_CNT_EN adds the 8-bit err_cnt output.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module conv_paralelo #(
    parameter int BYTE_W = 8,
    parameter int OUT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENB,
    input  logic [1:0]        PCLK,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in,
    output logic [OUT_W-1:0]  out,
    output logic              valid_out,
    output logic              err
`ifdef CONV_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [1:0] W32  = 2'b00;
    localparam logic [1:0] W16  = 2'b01;
    localparam logic [1:0] W8   = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                    state, state_next;
    logic [2:0]                cnt, cnt_next;
    logic [1:0]                width, width_next;
    // Holds the bytes received so far, right-aligned. It is cleared whenever a
    // word starts, so {sr, in} is already the zero-extended word at completion.
    logic [OUT_W-BYTE_W-1:0]   sr, sr_next;
    logic [OUT_W-1:0]          out_next;
    logic                      valid_next;
    logic                      err_next;
    logic                      start;
    logic [2:0]                cnt_inc;

    function automatic logic [2:0] bytes_for(input logic [1:0] w);
        case (w)
            W32:     bytes_for = 3'd4;
            W16:     bytes_for = 3'd2;
            default: bytes_for = 3'd1;
        endcase
    endfunction

    assign cnt_inc = cnt + 3'd1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        width_next = width;
        sr_next    = sr;
        out_next   = out;
        valid_next = 1'b0;
        err_next   = 1'b0;
        start      = 1'b0;

        if (!ENB) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (PCLK == RSVD) err_next = 1'b1;
                        else              start    = 1'b1;
                    end
                end
                COLLECT: begin
                    // The latched width is never RSVD, so a reserved code also
                    // lands here and aborts the partial word.
                    if (PCLK != width) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                        cnt_next   = 3'd0;
                        if (in_valid && (PCLK != RSVD)) start = 1'b1;
                    end else if (in_valid) begin
                        if (cnt_inc == bytes_for(width)) begin
                            out_next   = {sr, in};
                            valid_next = 1'b1;
                            state_next = IDLE;
                            cnt_next   = 3'd0;
                        end else begin
                            sr_next  = {sr[OUT_W-2*BYTE_W-1:0], in};
                            cnt_next = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end
            endcase

            // First byte of a new word, either from IDLE or right after an
            // abort caused by a width change.
            if (start) begin
                width_next = PCLK;
                if (PCLK == W8) begin
                    out_next   = {{(OUT_W-BYTE_W){1'b0}}, in};
                    valid_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    sr_next    = {{(OUT_W-2*BYTE_W){1'b0}}, in};
                    cnt_next   = 3'd1;
                    state_next = COLLECT;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            width     <= W32;
            sr        <= '0;
            out       <= '0;
            valid_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            width     <= width_next;
            sr        <= sr_next;
            out       <= out_next;
            valid_out <= valid_next;
            err       <= err_next;
        end
    end

`ifdef CONV_ERR_CNT_EN
    // Counts on the same edge that raises err and saturates at 8'hFF. ENB has
    // no effect on it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt <= 8'd0;
        end else if (err_next && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_paralelo.sv
`timescale 1ns/1ps

module tb_conv_paralelo;

    logic        CLK;
    logic        RST;
    logic        ENB;
    logic [1:0]  PCLK;
    logic        in_valid;
    logic [7:0]  in_b;
    logic [31:0] out;
    logic        valid_out;
    logic        err;
`ifdef CONV_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    conv_paralelo #(.BYTE_W(8), .OUT_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENB       (ENB),
        .PCLK      (PCLK),
        .in_valid  (in_valid),
        .in        (in_b),
        .out       (out),
        .valid_out (valid_out),
        .err       (err)
`ifdef CONV_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // The partial word is a plain list of the bytes received so far. A word is
    // emitted when the list reaches the byte count of its width.
    logic [7:0]  part_q[$];
    logic [1:0]  lw;
    logic [31:0] exp_out;
    logic        exp_v;
    logic        exp_e;
    int          exp_cnt;

    function automatic int nbytes(input logic [1:0] p);
        if (p == 2'b00) return 4;
        if (p == 2'b01) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        part_q.delete();
        lw      = 2'b00;
        exp_out = 32'h0;
        exp_v   = 1'b0;
        exp_e   = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (!ENB) begin
            part_q.delete();
        end else begin
            if (part_q.size() > 0 && (PCLK != lw || (in_valid && PCLK == 2'b11))) begin
                exp_e = 1'b1;
                part_q.delete();
            end
            if (in_valid) begin
                if (PCLK == 2'b11) begin
                    exp_e = 1'b1;
                end else begin
                    if (part_q.size() == 0) lw = PCLK;
                    part_q.push_back(in_b);
                    if (part_q.size() == nbytes(lw)) begin
                        w = 32'h0;
                        foreach (part_q[i]) w = (w << 8) | {24'h0, part_q[i]};
                        exp_out = w;
                        exp_v   = 1'b1;
                        part_q.delete();
                    end
                end
            end
        end
        if (exp_e && exp_cnt < 255) exp_cnt++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("out", out, exp_out);
        check("valid_out", {31'h0, valid_out}, {31'h0, exp_v});
        check("err", {31'h0, err}, {31'h0, exp_e});
`ifdef CONV_ERR_CNT_EN
        check("err_cnt", {24'h0, err_cnt}, exp_cnt[31:0]);
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge. Drives one cycle, then checks the
    // registered outputs 1 ns after the rising edge.
    task automatic cycle(input logic e, input logic [1:0] p, input logic v, input logic [7:0] b);
        ENB      = e;
        PCLK     = p;
        in_valid = v;
        in_b     = b;
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    // Asserted between edges so that the asynchronous clear is observed at once.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_out_async", out, 32'h0);
        compare_all();
        @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] cur_p;
        RST      = 1'b0;
        ENB      = 1'b0;
        PCLK     = 2'b00;
        in_valid = 1'b0;
        in_b     = 8'h00;
        model_reset();
        @(negedge CLK);
        do_reset();

        // 32-bit word
        cycle(1, 2'b00, 1, 8'h0F);
        check("w32_no_early_valid", {31'h0, valid_out}, 32'h0);
        cycle(1, 2'b00, 1, 8'h00);
        cycle(1, 2'b00, 1, 8'hFF);
        cycle(1, 2'b00, 1, 8'h55);
        check("w32_out", out, 32'h0F00_FF55);
        check("w32_model", exp_out, 32'h0F00_FF55);
        check("w32_valid", {31'h0, valid_out}, 32'h1);
        check("w32_err", {31'h0, err}, 32'h0);
        cycle(1, 2'b00, 0, 8'h00);
        check("w32_valid_one_cycle", {31'h0, valid_out}, 32'h0);

        // 16-bit word with a gap
        cycle(1, 2'b01, 1, 8'h30);
        cycle(1, 2'b01, 0, 8'h00);
        check("w16_gap1", {31'h0, valid_out}, 32'h0);
        cycle(1, 2'b01, 0, 8'h00);
        check("w16_gap2", {31'h0, valid_out}, 32'h0);
        cycle(1, 2'b01, 1, 8'hEA);
        check("w16_out", out, 32'h0000_30EA);
        check("w16_valid", {31'h0, valid_out}, 32'h1);

        // 8-bit back-to-back
        cycle(1, 2'b10, 1, 8'hAE);
        check("w8_a", out, 32'h0000_00AE);
        check("w8_a_valid", {31'h0, valid_out}, 32'h1);
        cycle(1, 2'b10, 1, 8'h12);
        check("w8_b", out, 32'h0000_0012);
        cycle(1, 2'b10, 1, 8'h34);
        check("w8_c", out, 32'h0000_0034);
        check("w8_c_valid", {31'h0, valid_out}, 32'h1);

        // Width change mid-word
        cycle(1, 2'b00, 1, 8'h11);
        cycle(1, 2'b00, 1, 8'h22);
        cycle(1, 2'b10, 1, 8'h33);
        check("chg_out", out, 32'h0000_0033);
        check("chg_model", exp_out, 32'h0000_0033);
        check("chg_err", {31'h0, err}, 32'h1);
        check("chg_valid", {31'h0, valid_out}, 32'h1);

        // Reserved code, then ENB drop mid-word
        cycle(1, 2'b11, 1, 8'h77);
        check("rsvd_err", {31'h0, err}, 32'h1);
        check("rsvd_out_held", out, 32'h0000_0033);
        cycle(1, 2'b00, 1, 8'hA0);
        cycle(1, 2'b00, 1, 8'hA1);
        cycle(0, 2'b00, 1, 8'hA2);
        check("enb_no_err", {31'h0, err}, 32'h0);
        check("enb_no_valid", {31'h0, valid_out}, 32'h0);
        cycle(1, 2'b00, 1, 8'h01);
        cycle(1, 2'b00, 1, 8'h02);
        cycle(1, 2'b00, 1, 8'h03);
        cycle(1, 2'b00, 1, 8'h04);
        check("enb_fresh_out", out, 32'h0102_0304);
        check("enb_fresh_valid", {31'h0, valid_out}, 32'h1);

        // Reset between bytes 2 and 3
        cycle(1, 2'b00, 1, 8'hA1);
        cycle(1, 2'b00, 1, 8'hB2);
        do_reset();
        cycle(1, 2'b00, 1, 8'hC1);
        cycle(1, 2'b00, 1, 8'hC2);
        cycle(1, 2'b00, 1, 8'hC3);
        cycle(1, 2'b00, 1, 8'hC4);
        check("rst_fresh_out", out, 32'hC1C2_C3C4);

        // Randomized traffic
        cur_p = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) cur_p = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 19) != 0), cur_p, ($urandom_range(0, 3) != 0),
                      8'($urandom_range(0, 255)));
            end
        end

        // 300 error events drive the optional counter into saturation
        for (int i = 0; i < 300; i++) cycle(1, 2'b11, 1, 8'h77);
`ifdef CONV_ERR_CNT_EN
        check("err_cnt_sat", {24'h0, err_cnt}, 32'h0000_00FF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
